// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - CHIP-8 framebuffer scanout to 640x480@60 VGA
//
// Reads the 16-bit framebuffer through a private read port, scales the
// 64x32 (lores) or 128x64 (hires) image by 10 or 5 and drives VGA pixel/sync.
//
// Ports:
//   clk        in   pixel clock (25.175 MHz nominal)
//   reset_n    in   asynchronous active-low reset, synchronous release
//   hires      in   resolution select, sampled at (h=0, v=0) only
//   fb_addr    out  [8:0] framebuffer word address, held while fb_rd=0
//   fb_rd      out  one-clock read strobe per word
//   fb_data    in   [15:0] read data, valid 1 clk after fb_rd
//   pixel      out  pixel value, 0 outside the image area
//   active     out  visible 640x480 region
//   hsync_n    out  horizontal sync, active low
//   vsync_n    out  vertical sync, active low
//   frame_tick out  1-clk pulse at (h=0, v=480); only with SCANOUT_FRAME_TICK_EN
//
// pixel/active/hsync_n/vsync_n describe counter position (h,v) two clocks
// after the counters hold (h,v).
module framebuffer_scanout (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hires,
  output logic [8:0]  fb_addr,
  output logic        fb_rd,
  input  logic [15:0] fb_data,
  output logic        pixel,
  output logic        active,
  output logic        hsync_n,
`ifdef SCANOUT_FRAME_TICK_EN
  output logic        vsync_n,
  output logic        frame_tick
`else
  output logic        vsync_n
`endif
);

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_OFFSET  = 80;
  localparam int V_IMAGE   = 320;

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] H_HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  // Word 0 of a line is requested at h=798; the strobe is registered one clock earlier.
  localparam logic [9:0] H_FETCH0 = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 3);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_IMG0   = 10'(V_OFFSET);
  localparam logic [9:0] V_IMG1   = 10'(V_OFFSET + V_IMAGE - 1);

  // Raster position
  logic [9:0] h_q, h_d, v_q, v_d, v_next;
  logic       hires_q;

  // Scale sub-counters: csub = h mod S, col = h / S; rsub/row track image row
  logic [3:0] csub_q, csub_d, rsub_q, rsub_d;
  logic [7:0] col_q, col_d;
  logic [5:0] row_q, row_d;
  logic [3:0] scale_last, fetch_sub;

  // Fetch path
  logic       fb_rd_q, rd_d1_q, rd_word0, rd_wordk;
  logic [8:0] fb_addr_q, addr_d;
  logic [15:0] prefetch_q, shift_q;

  // Output pipeline
  logic act_s1_q, img_s1_q, hs_s1_q, vs_s1_q;
  logic pixel_q, active_q, hsync_q, vsync_q;
  logic in_img_line, next_img_line;

  assign scale_last = hires_q ? 4'd4 : 4'd9;
  assign fetch_sub  = hires_q ? 4'd2 : 4'd7;

  always_comb begin
    h_d    = h_q + 10'd1;
    v_d    = v_q;
    v_next = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    if (h_q == H_LAST) begin
      h_d = 10'd0;
      v_d = v_next;
    end
  end

  assign in_img_line   = (v_q >= V_IMG0) && (v_q <= V_IMG1);
  assign next_img_line = (v_next >= V_IMG0) && (v_next <= V_IMG1);

  always_comb begin
    csub_d = csub_q + 4'd1;
    col_d  = col_q;
    if (h_q == H_LAST) begin
      csub_d = 4'd0;
      col_d  = 8'd0;
    end else if (csub_q == scale_last) begin
      csub_d = 4'd0;
      col_d  = col_q + 8'd1;
    end
  end

  // The row tracker steps at h=640, after the line's last fetch, so from
  // then on it names the row of the following line (needed by the h=798 fetch).
  always_comb begin
    rsub_d = rsub_q;
    row_d  = row_q;
    if (h_q == H_VIS) begin
      if (v_next == V_IMG0) begin
        rsub_d = 4'd0;
        row_d  = 6'd0;
      end else if (rsub_q == scale_last) begin
        rsub_d = 4'd0;
        row_d  = row_q + 6'd1;
      end else begin
        rsub_d = rsub_q + 4'd1;
      end
    end
  end

  // Word k>0 is requested at h = k*16*S - 2; condition evaluated one clock
  // earlier, where col = 16k-1 and csub = S-3.
  assign rd_word0 = (h_q == H_FETCH0) && next_img_line;
  assign rd_wordk = in_img_line && (h_q < H_VIS) && (csub_q == fetch_sub) &&
                    (col_q[3:0] == 4'hF) &&
                    (hires_q ? (col_q[7:4] < 4'd7) : (col_q[7:4] < 4'd3));

  always_comb begin
    if (hires_q) begin
      addr_d = rd_word0 ? {row_q, 3'd0} : {row_q, col_q[6:4] + 3'd1};
    end else begin
      addr_d = rd_word0 ? {2'b00, row_q[4:0], 2'd0}
                        : {2'b00, row_q[4:0], col_q[5:4] + 2'd1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q        <= '0;
      v_q        <= '0;
      hires_q    <= 1'b0;
      csub_q     <= '0;
      col_q      <= '0;
      rsub_q     <= '0;
      row_q      <= '0;
      fb_rd_q    <= 1'b0;
      fb_addr_q  <= '0;
      rd_d1_q    <= 1'b0;
      prefetch_q <= '0;
      shift_q    <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      csub_q  <= csub_d;
      col_q   <= col_d;
      rsub_q  <= rsub_d;
      row_q   <= row_d;
      if (h_q == 10'd0 && v_q == 10'd0) hires_q <= hires;
      fb_rd_q <= rd_word0 | rd_wordk;
      if (rd_word0 | rd_wordk) fb_addr_q <= addr_d;
      rd_d1_q <= fb_rd_q;
      if (rd_d1_q) prefetch_q <= fb_data;
      // Load at each word boundary, otherwise step once per S clocks.
      // The MSB seen with counter h+1 is the image bit for position h.
      if (csub_q == 4'd0) begin
        if (col_q[3:0] == 4'd0) shift_q <= prefetch_q;
        else                    shift_q <= {shift_q[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_s1_q <= 1'b0;
      img_s1_q <= 1'b0;
      hs_s1_q  <= 1'b1;
      vs_s1_q  <= 1'b1;
      pixel_q  <= 1'b0;
      active_q <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
    end else begin
      act_s1_q <= (h_q < H_VIS) && (v_q < V_VIS);
      img_s1_q <= (h_q < H_VIS) && in_img_line;
      hs_s1_q  <= !((h_q >= H_HS_BEG) && (h_q <= H_HS_END));
      vs_s1_q  <= !((v_q >= V_VS_BEG) && (v_q <= V_VS_END));
      pixel_q  <= img_s1_q & shift_q[15];
      active_q <= act_s1_q;
      hsync_q  <= hs_s1_q;
      vsync_q  <= vs_s1_q;
    end
  end

  assign fb_rd   = fb_rd_q;
  assign fb_addr = fb_addr_q;
  assign pixel   = pixel_q;
  assign active  = active_q;
  assign hsync_n = hsync_q;
  assign vsync_n = vsync_q;

`ifdef SCANOUT_FRAME_TICK_EN
  logic frame_tick_q;
  // High while the counters hold (h=0, v=480).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_tick_q <= 1'b0;
    else          frame_tick_q <= (h_q == H_LAST) && (v_q == V_VIS - 10'd1);
  end
  assign frame_tick = frame_tick_q;
`endif

endmodule
